pkt_buffer_ring: RTL and testbench
==================================

Name: pkt_buffer_ring

Overview:
- Parametrised successor to the single-packet receive store.
- Writes received payload bytes into a circular packet RAM. Commits a frame only if its CRC is good and no error was flagged; otherwise rolls the write pointer back.
- Queues a {start address, length} descriptor per committed frame.
- Streams committed frames out through a valid/ready read port. Sits between the RX MAC FSM and the downstream packet consumer.

Parameters:
- DATA_W, 8, byte-lane width of irx_d and read data
- ADDR_W, 14, packet RAM address width; capacity 2^ADDR_W words
- LEN_W, 11, frame length width; max accepted length 2^LEN_W-1
- DESC_LOG2, 2, descriptor FIFO depth = 2^DESC_LOG2 frames

Ports:
- iclk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- idv  in  1  RX data valid
- irx_d  in  DATA_W  RX data byte
- iFSM_state  in  3  RX FSM state; 3'b000/3'b001 = preamble/SFD (not stored), others = payload
- i_crc_correct  in  1  CRC good, sampled at end of frame
- i_error  in  1  RX error, sampled at end of frame
- o_pkt_avail  out  1  at least one committed frame queued
- o_pkt_len  out  LEN_W  length of head frame (valid when o_pkt_avail)
- i_rd_start  in  1  pulse: begin streaming head frame
- o_rd_valid  out  1  o_rd_data valid
- o_rd_data  out  DATA_W  read byte
- o_rd_last  out  1  last byte of frame, qualified by o_rd_valid
- i_rd_ready  in  1  consumer accepts byte when o_rd_valid & i_rd_ready
- o_commit_cnt  out  16  committed frames, saturating
- o_drop_cnt  out  16  dropped frames, saturating

Behaviour:
- Reset: wr_ptr, commit_ptr, rd_ptr, free_ptr (all ADDR_W+1 bits) = 0; descriptor FIFO empty; both FSMs idle. All outputs 0.
- Write FSM states: W_IDLE, W_RECV, W_DROP.
  - W_IDLE -> W_RECV: first cycle with idv=1 and iFSM_state not in {000,001}; that byte is stored.
  - In W_RECV, each such cycle writes irx_d at wr_ptr[ADDR_W-1:0], increments wr_ptr and the frame length counter.
- End of frame = idv=0 while in W_RECV or W_DROP; evaluated that cycle.
  - Commit if i_crc_correct=1, i_error=0, length 1..2^LEN_W-1, and descriptor FIFO not full.
  - Commit action: push {commit_ptr, len}, commit_ptr <= wr_ptr, o_commit_cnt++.
  - Any other end of frame is a drop: wr_ptr <= commit_ptr, o_drop_cnt++.
  - Both paths return to W_IDLE.
- Overflow:
  - If a store would make wr_ptr - free_ptr exceed 2^ADDR_W, or the length counter would exceed 2^LEN_W-1: the byte is not written, wr_ptr <= commit_ptr, go to W_DROP.
  - W_DROP ignores bytes until end of frame, then counts one drop and returns to W_IDLE.
- Addressing wraps modulo 2^ADDR_W. Full/empty is distinguished by the extra pointer MSB.
- RAM: one write port, one read port, synchronous read, 1-cycle latency. Simultaneous write and read at the same address cannot occur, because free space excludes unreleased frames.
- Read FSM states: R_IDLE, R_FETCH, R_STREAM.
  - R_IDLE: i_rd_start while o_pkt_avail -> load rd_ptr and remaining count from the head descriptor, issue first RAM read, go to R_FETCH.
  - i_rd_start ignored when no frame is available or not in R_IDLE.
  - R_FETCH (1 cycle) -> R_STREAM with o_rd_valid=1.
- Streaming:
  - o_rd_data is held stable while o_rd_valid & !i_rd_ready.
  - On each accept, the next word is prefetched so back-to-back accepts give 1 byte/cycle.
  - o_rd_last=1 when remaining count = 1.
- Frame release: on accept of the last byte, pop the descriptor, free_ptr <= free_ptr + len, o_rd_valid=0 next cycle, go to R_IDLE. First possible new i_rd_start is the following cycle.
- Simultaneous events:
  - Commit push and read pop in the same cycle are both applied; descriptor count unchanged.
  - free_ptr release and an overflow check in the same cycle use the pre-release free_ptr (conservative).
- Counters saturate at 16'hFFFF.
- Reset mid-frame or mid-read aborts everything. Partial data is lost and not counted.

Test Plan:
- Single frame: 64 payload bytes 0x00..0x3F, CRC ok -> o_pkt_avail=1, o_pkt_len=64. Read with i_rd_ready=1 yields 0x00..0x3F on 64 consecutive cycles, o_rd_last on 0x3F. o_commit_cnt=1.
- Bad frame: 100 bytes with i_crc_correct=0, then 20-byte good frame -> only the 20-byte frame is readable at address 0. o_drop_cnt=1, o_commit_cnt=1.
- Descriptor full: 5 good 10-byte frames, DESC_LOG2=2, no reads -> first 4 committed, 5th dropped. After reading one frame, a 6th frame commits.
- Wrap/overflow (ADDR_W=6): 40-byte frame committed and read, then 40-byte frame -> stored across the wrap, reads correctly. Then two 40-byte frames with no reads -> second overflows, enters W_DROP, o_drop_cnt increments.
- Backpressure: i_rd_ready toggled 1,0,0,1 during a stream -> o_rd_data holds during stalls, no bytes lost or duplicated, o_rd_last exactly once.
- Reset mid-frame after 30 bytes -> all outputs 0, o_pkt_avail=0. Next 8-byte good frame is stored at address 0.

Source files
------------

// File: rtl/pkt_buffer_ring.sv
// pkt_buffer_ring
//   Circular receive packet store. Payload bytes from the RX MAC are written
//   into a packet RAM; a frame is committed (descriptor pushed) only when its
//   CRC is good and no error was flagged, otherwise the write pointer rolls
//   back to the last commit point. Committed frames are streamed out through
//   a valid/ready read port in arrival order.
//
// Ports
//   iclk, i_rst          clock (rising edge), synchronous active-high reset
//   idv, irx_d           RX data valid / RX byte
//   iFSM_state           RX FSM state; 000/001 = preamble/SFD, others = payload
//   i_crc_correct        CRC good, sampled at end of frame
//   i_error              RX error, sampled at end of frame
//   o_pkt_avail          at least one committed frame queued
//   o_pkt_len            length of head frame (0 when none)
//   i_rd_start           pulse: begin streaming head frame
//   o_rd_valid/o_rd_data/o_rd_last/i_rd_ready   read stream handshake
//   o_commit_cnt         committed frames, saturating
//   o_drop_cnt           dropped frames, saturating
module pkt_buffer_ring #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned DESC_LOG2 = 2
) (
  input  logic              iclk,
  input  logic              i_rst,
  input  logic              idv,
  input  logic [DATA_W-1:0] irx_d,
  input  logic [2:0]        iFSM_state,
  input  logic              i_crc_correct,
  input  logic              i_error,
  output logic              o_pkt_avail,
  output logic [LEN_W-1:0]  o_pkt_len,
  input  logic              i_rd_start,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  input  logic              i_rd_ready,
  output logic [15:0]       o_commit_cnt,
  output logic [15:0]       o_drop_cnt
);

  localparam int unsigned PW        = ADDR_W + 1;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;
  localparam int unsigned DESC_DEPTH = 1 << DESC_LOG2;

  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]    CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wstate_e           wstate_q, wstate_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       commit_cnt_q, commit_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  rstate_e           rstate_q, rstate_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     free_ptr_q, free_ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic [DATA_W-1:0] ram_q [RAM_DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic [PW-1:0]     desc_start_q [DESC_DEPTH];
  logic [LEN_W-1:0]  desc_len_q   [DESC_DEPTH];
  logic [DESC_LOG2:0] desc_wp_q, desc_rp_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              payload;
  logic [PW-1:0]     used;
  logic              ram_full;
  logic              len_max;
  logic              desc_empty;
  logic              desc_full;
  logic              eof_ok;
  logic [PW-1:0]     head_start;
  logic [LEN_W-1:0]  head_len;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic              desc_push;
  logic              desc_pop;

  assign payload    = idv && (iFSM_state != 3'b000) && (iFSM_state != 3'b001);
  // Occupancy includes frames committed but not yet released by the reader,
  // so the writer can never overrun data that is still to be streamed.
  assign used       = wr_ptr_q - free_ptr_q;
  assign ram_full   = (used == CAPACITY);
  assign len_max    = (len_q == '1);
  assign desc_empty = (desc_wp_q == desc_rp_q);
  assign desc_full  = (desc_wp_q[DESC_LOG2] != desc_rp_q[DESC_LOG2]) &&
                      (desc_wp_q[DESC_LOG2-1:0] == desc_rp_q[DESC_LOG2-1:0]);
  assign eof_ok     = i_crc_correct && !i_error && (len_q != '0) && !desc_full;
  assign head_start = desc_start_q[desc_rp_q[DESC_LOG2-1:0]];
  assign head_len   = desc_len_q[desc_rp_q[DESC_LOG2-1:0]];

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    wstate_d     = wstate_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    commit_cnt_d = commit_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ram_we       = 1'b0;
    desc_push    = 1'b0;

    unique case (wstate_q)
      W_IDLE, W_RECV: begin
        if ((wstate_q == W_RECV) && !idv) begin
          // End of frame: commit or roll back.
          if (eof_ok) begin
            desc_push    = 1'b1;
            commit_ptr_d = wr_ptr_q;
            if (commit_cnt_q != '1) commit_cnt_d = commit_cnt_q + 16'd1;
          end else begin
            wr_ptr_d = commit_ptr_q;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
          end
          len_d    = '0;
          wstate_d = W_IDLE;
        end else if (payload) begin
          if (ram_full || len_max) begin
            // Byte would not fit: discard the frame so far and swallow the rest.
            wr_ptr_d = commit_ptr_q;
            len_d    = '0;
            wstate_d = W_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = len_q + LEN_ONE;
            wstate_d = W_RECV;
          end
        end
      end
      W_DROP: begin
        if (!idv) begin
          wr_ptr_d = commit_ptr_q;
          len_d    = '0;
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rstate_d   = rstate_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    free_ptr_d = free_ptr_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_ptr_q[ADDR_W-1:0];
    desc_pop   = 1'b0;

    unique case (rstate_q)
      R_IDLE: begin
        if (i_rd_start && !desc_empty) begin
          ram_re    = 1'b1;
          ram_raddr = head_start[ADDR_W-1:0];
          rd_ptr_d  = head_start + PTR_ONE;
          rem_d     = head_len;
          rstate_d  = R_FETCH;
        end
      end
      R_FETCH: rstate_d = R_STREAM;
      R_STREAM: begin
        if (i_rd_ready) begin
          if (rem_q == LEN_ONE) begin
            desc_pop   = 1'b1;
            free_ptr_d = free_ptr_q + PW'(head_len);
            rstate_d   = R_IDLE;
          end else begin
            // Prefetch the next byte on every accept; the RAM output register
            // only updates on a read, so stalled data stays put.
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rem_d    = rem_q - LEN_ONE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      wstate_q     <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      len_q        <= '0;
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
      rstate_q     <= R_IDLE;
      rd_ptr_q     <= '0;
      free_ptr_q   <= '0;
      rem_q        <= '0;
      rd_data_q    <= '0;
      desc_wp_q    <= '0;
      desc_rp_q    <= '0;
    end else begin
      wstate_q     <= wstate_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      len_q        <= len_d;
      commit_cnt_q <= commit_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      rstate_q     <= rstate_d;
      rd_ptr_q     <= rd_ptr_d;
      free_ptr_q   <= free_ptr_d;
      rem_q        <= rem_d;
      if (ram_re) rd_data_q <= ram_q[ram_raddr];
      if (desc_push) desc_wp_q <= desc_wp_q + 1'b1;
      if (desc_pop)  desc_rp_q <= desc_rp_q + 1'b1;
    end
  end

  // Storage arrays carry no reset; their contents are only observed through
  // pointers that are reset.
  always_ff @(posedge iclk) begin
    if (ram_we) ram_q[wr_ptr_q[ADDR_W-1:0]] <= irx_d;
    if (desc_push && !i_rst) begin
      desc_start_q[desc_wp_q[DESC_LOG2-1:0]] <= commit_ptr_q;
      desc_len_q[desc_wp_q[DESC_LOG2-1:0]]   <= len_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_pkt_avail  = !desc_empty;
  assign o_pkt_len    = desc_empty ? '0 : head_len;
  assign o_rd_valid   = (rstate_q == R_STREAM);
  assign o_rd_data    = rd_data_q;
  assign o_rd_last    = (rstate_q == R_STREAM) && (rem_q == LEN_ONE);
  assign o_commit_cnt = commit_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_buffer_ring.sv
// Testbench for pkt_buffer_ring (small 64-byte ring so wrap and overflow are
// reachable). Reference model: committed frames held as a byte queue plus a
// length queue; acceptance decided from frame attributes and free space.
module tb_pkt_buffer_ring;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned LEN_W     = 11;
  localparam int unsigned DESC_LOG2 = 2;
  localparam int CAP    = 1 << ADDR_W;
  localparam int DDEPTH = 1 << DESC_LOG2;
  localparam int MAXLEN = (1 << LEN_W) - 1;

  logic              iclk = 1'b0;
  logic              i_rst;
  logic              idv;
  logic [DATA_W-1:0] irx_d;
  logic [2:0]        iFSM_state;
  logic              i_crc_correct;
  logic              i_error;
  logic              o_pkt_avail;
  logic [LEN_W-1:0]  o_pkt_len;
  logic              i_rd_start;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_last;
  logic              i_rd_ready;
  logic [15:0]       o_commit_cnt;
  logic [15:0]       o_drop_cnt;

  pkt_buffer_ring #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .DESC_LOG2(DESC_LOG2)
  ) dut (
    .iclk         (iclk),
    .i_rst        (i_rst),
    .idv          (idv),
    .irx_d        (irx_d),
    .iFSM_state   (iFSM_state),
    .i_crc_correct(i_crc_correct),
    .i_error      (i_error),
    .o_pkt_avail  (o_pkt_avail),
    .o_pkt_len    (o_pkt_len),
    .i_rd_start   (i_rd_start),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_rd_last    (o_rd_last),
    .i_rd_ready   (i_rd_ready),
    .o_commit_cnt (o_commit_cnt),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 iclk = ~iclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] mdl_data[$];
  int         mdl_len[$];
  int         mdl_commit = 0;
  int         mdl_drop   = 0;

  // Scoreboard of bytes the read port must produce, in order
  logic [7:0] exp_d[$];
  logic       exp_l[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented byte against the scoreboard head.
  always @(negedge iclk) begin
    if (i_rst === 1'b0 && o_rd_valid === 1'b1) begin
      if (exp_d.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: o_rd_valid got 1 expected 0 at %0t", $time);
      end else if (i_rd_ready) begin
        check("rd_data", o_rd_data, exp_d[0]);
        check("rd_last", o_rd_last, exp_l[0]);
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
      end else begin
        check("rd_hold", o_rd_data, exp_d[0]);
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check_status();
    check("commit_cnt", o_commit_cnt, mdl_commit);
    check("drop_cnt", o_drop_cnt, mdl_drop);
    check("pkt_avail", o_pkt_avail, mdl_len.size() != 0);
    check("pkt_len", o_pkt_len, (mdl_len.size() != 0) ? mdl_len[0] : 0);
  endtask

  task automatic frame_begin();
    idv = 1'b1;
    iFSM_state = 3'b000;
    irx_d = 8'h55;
    tick();
    tick();
    iFSM_state = 3'b001;
    irx_d = 8'hD5;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    idv = 1'b1;
    iFSM_state = 3'($urandom_range(2, 7));
    irx_d = b;
    tick();
  endtask

  task automatic frame_end(input logic crc, input logic err);
    idv = 1'b0;
    i_crc_correct = crc;
    i_error = err;
    tick();
    i_crc_correct = 1'b0;
    i_error = 1'b0;
    tick();
  endtask

  // base >= 0: bytes base, base+1, ...; base < 0: random bytes
  task automatic send_frame(input int len, input logic crc, input logic err, input int base);
    logic [7:0] bytes[$];
    bit commit;
    for (int i = 0; i < len; i++)
      bytes.push_back((base >= 0) ? 8'(base + i) : 8'($urandom_range(0, 255)));
    frame_begin();
    foreach (bytes[i]) push_byte(bytes[i]);
    frame_end(crc, err);
    commit = crc && !err && (len >= 1) && (len <= MAXLEN) &&
             (mdl_len.size() < DDEPTH) && (mdl_data.size() + len <= CAP);
    if (commit) begin
      foreach (bytes[i]) mdl_data.push_back(bytes[i]);
      mdl_len.push_back(len);
      if (mdl_commit < 16'hFFFF) mdl_commit++;
    end else begin
      if (mdl_drop < 16'hFFFF) mdl_drop++;
    end
    check_status();
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic read_frame(input int mode);
    int len;
    int cyc;
    if (mdl_len.size() == 0) begin
      // Start with nothing queued must be ignored; the monitor flags any valid.
      i_rd_start = 1'b1;
      tick();
      i_rd_start = 1'b0;
      repeat (3) tick();
      check("idle_avail", o_pkt_avail, 0);
      check("idle_valid", o_rd_valid, 0);
      return;
    end
    len = mdl_len[0];
    check("pre_avail", o_pkt_avail, 1);
    check("pre_len", o_pkt_len, len);
    void'(mdl_len.pop_front());
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(mdl_data.pop_front());
      exp_l.push_back(i == len - 1);
    end
    i_rd_ready = 1'b0;
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    cyc = 0;
    while (exp_d.size() != 0 && cyc < 8 * len + 20) begin
      case (mode)
        0: i_rd_ready = 1'b1;
        1: i_rd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: i_rd_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
    end
    if (exp_d.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_timeout: %0d bytes outstanding, required 0", exp_d.size());
      exp_d.delete();
      exp_l.delete();
    end
    // Start edge, one fetch cycle, then one byte per cycle.
    if (mode == 0) check("stream_cycles", cyc, len + 1);
    i_rd_ready = 1'b0;
    tick();
    check("post_valid", o_rd_valid, 0);
    check_status();
  endtask

  task automatic check_reset_outputs();
    check("rst_avail", o_pkt_avail, 0);
    check("rst_len", o_pkt_len, 0);
    check("rst_valid", o_rd_valid, 0);
    check("rst_data", o_rd_data, 0);
    check("rst_last", o_rd_last, 0);
    check("rst_commit", o_commit_cnt, 0);
    check("rst_drop", o_drop_cnt, 0);
  endtask

  initial begin
    i_rst = 1'b1;
    idv = 1'b0;
    irx_d = '0;
    iFSM_state = 3'b000;
    i_crc_correct = 1'b0;
    i_error = 1'b0;
    i_rd_start = 1'b0;
    i_rd_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs();
    i_rst = 1'b0;
    tick();

    // Full-capacity frame, read at full rate
    send_frame(64, 1'b1, 1'b0, 0);
    read_frame(0);

    // Bad CRC (overflows as well), then a good frame
    send_frame(100, 1'b0, 1'b0, 8'h80);
    send_frame(20, 1'b1, 1'b0, 8'h10);
    read_frame(0);
    // Error flag with good CRC is a drop
    send_frame(12, 1'b1, 1'b1, 8'h40);

    // Descriptor FIFO full
    for (int f = 0; f < 5; f++) send_frame(10, 1'b1, 1'b0, 16 * f);
    read_frame(0);
    send_frame(10, 1'b1, 1'b0, 8'hA0);
    for (int f = 0; f < 4; f++) read_frame(f % 3);

    // Wrap and overflow
    send_frame(40, 1'b1, 1'b0, 8'h20);
    read_frame(0);
    send_frame(40, 1'b1, 1'b0, 8'h60);
    read_frame(0);
    send_frame(40, 1'b1, 1'b0, 8'hC0);
    send_frame(40, 1'b1, 1'b0, 8'h00);
    read_frame(1);

    // Start with nothing available
    read_frame(0);

    // Reset in the middle of a frame
    send_frame(5, 1'b1, 1'b0, 8'h33);
    frame_begin();
    for (int i = 0; i < 30; i++) push_byte(8'(i));
    idv = 1'b0;
    i_rst = 1'b1;
    tick();
    check_reset_outputs();
    tick();
    i_rst = 1'b0;
    mdl_data.delete();
    mdl_len.delete();
    mdl_commit = 0;
    mdl_drop = 0;
    tick();
    send_frame(8, 1'b1, 1'b0, 8'hE0);
    read_frame(0);

    // Randomised traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1 || mdl_len.size() == 0)
        send_frame($urandom_range(1, 48), 1'($urandom_range(0, 9) != 0),
                   1'($urandom_range(0, 9) == 0), -1);
      else
        read_frame($urandom_range(0, 2));
    end
    while (mdl_len.size() != 0) read_frame(2);
    check_status();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
